// File: rtl/ldpc_frame_sched.sv
// Two-bank ping-pong scheduler: fills a bank from the word stream, runs the parity
// core on it, then holds it for the frame consumer until acknowledged.
module ldpc_frame_sched #(
  parameter int DATA_WIDTH = 360,
  parameter int ADDR_WIDTH = 7,
  parameter int K_WORDS    = 72,
  parameter int TIMEOUT    = 65535
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  output logic                  buf_we,
  output logic                  buf_bank,
  output logic [ADDR_WIDTH-1:0] buf_wr_addr,
  output logic [DATA_WIDTH-1:0] buf_wr_data,
  output logic                  core_en,
  output logic                  core_bank,
  output logic                  core_clr,
  input  logic                  core_done,
  output logic                  frm_valid,
  output logic                  frm_bank,
  input  logic                  frm_ack,
  output logic                  err_len,
  output logic                  err_timeout,
  output logic                  busy
);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0]         T_LAST = TW'(TIMEOUT - 1);
  localparam logic [ADDR_WIDTH-1:0] W_LAST = ADDR_WIDTH'(K_WORDS - 1);

  typedef enum logic [1:0] {EMPTY, FULL, ENC, DONE} bank_t;
  typedef enum logic [1:0] {C_IDLE, C_RUN, C_CLR} core_t;

  bank_t                 bank_reg [2];
  bank_t                 bank_next [2];
  logic                  wr_bank_reg, enc_bank_reg, rd_bank_reg;
  logic [ADDR_WIDTH-1:0] wcnt_reg;
  logic [TW-1:0]         timer_reg;
  core_t                 state_reg, state_next;
  logic                  core_en_reg, core_en_next;
  logic                  core_clr_reg, core_clr_next;
  logic                  core_bank_reg, core_bank_next;
  logic                  err_len_reg, err_timeout_reg;
  logic                  buf_we_reg, buf_bank_reg;
  logic [ADDR_WIDTH-1:0] buf_wr_addr_reg;
  logic [DATA_WIDTH-1:0] buf_wr_data_reg;

  logic accept, at_last, close, len_bad, rd_ack;
  logic start, enc_done, enc_drop;
  logic [1:0] set_full, set_enc, set_done, set_empty;

  assign in_ready  = !rst && (bank_reg[wr_bank_reg] == EMPTY);
  assign frm_valid = !rst && (bank_reg[rd_bank_reg] == DONE);
  assign frm_bank  = rd_bank_reg;

  assign accept  = in_valid & in_ready;
  assign at_last = (wcnt_reg == W_LAST);
  assign close   = accept & (in_last | at_last);
  assign len_bad = close & (in_last ^ at_last);
  assign rd_ack  = frm_valid & frm_ack;

  // Each bank's events are mutually exclusive because each needs a different current state.
  for (genvar gi = 0; gi < 2; gi++) begin : g_bank_evt
    assign set_full[gi]  = close & (wr_bank_reg == 1'(gi));
    assign set_enc[gi]   = start & (enc_bank_reg == 1'(gi));
    assign set_done[gi]  = enc_done & (enc_bank_reg == 1'(gi));
    assign set_empty[gi] = (enc_drop & (enc_bank_reg == 1'(gi))) |
                           (rd_ack & (rd_bank_reg == 1'(gi)));
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      bank_next[i] = bank_reg[i];
      if (set_full[i])  bank_next[i] = FULL;
      if (set_enc[i])   bank_next[i] = ENC;
      if (set_done[i])  bank_next[i] = DONE;
      if (set_empty[i]) bank_next[i] = EMPTY;
    end
  end

  always_comb begin
    state_next     = state_reg;
    core_en_next   = 1'b0;
    core_clr_next  = 1'b0;
    core_bank_next = core_bank_reg;
    start          = 1'b0;
    enc_done       = 1'b0;
    enc_drop       = 1'b0;
    case (state_reg)
      C_IDLE: begin
        if (bank_reg[enc_bank_reg] == FULL) begin
          start          = 1'b1;
          core_en_next   = 1'b1;
          core_bank_next = enc_bank_reg;
          state_next     = C_RUN;
        end
      end
      C_RUN: begin
        if (core_done) begin
          enc_done      = 1'b1;
          core_clr_next = 1'b1;
          state_next    = C_CLR;
        end else if (timer_reg == T_LAST) begin
          enc_drop      = 1'b1;
          core_clr_next = 1'b1;
          state_next    = C_CLR;
        end else begin
          core_en_next = 1'b1;
        end
      end
      C_CLR: begin
        if (!core_done) state_next = C_IDLE;
      end
      default: state_next = C_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) bank_reg[i] <= EMPTY;
      wr_bank_reg     <= 1'b0;
      enc_bank_reg    <= 1'b0;
      rd_bank_reg     <= 1'b0;
      wcnt_reg        <= '0;
      timer_reg       <= '0;
      state_reg       <= C_IDLE;
      core_en_reg     <= 1'b0;
      core_clr_reg    <= 1'b0;
      core_bank_reg   <= 1'b0;
      err_len_reg     <= 1'b0;
      err_timeout_reg <= 1'b0;
      buf_we_reg      <= 1'b0;
      buf_bank_reg    <= 1'b0;
      buf_wr_addr_reg <= '0;
      buf_wr_data_reg <= '0;
    end else begin
      for (int i = 0; i < 2; i++) bank_reg[i] <= bank_next[i];
      state_reg     <= state_next;
      core_en_reg   <= core_en_next;
      core_clr_reg  <= core_clr_next;
      core_bank_reg <= core_bank_next;

      buf_we_reg <= accept;
      if (accept) begin
        buf_bank_reg    <= wr_bank_reg;
        buf_wr_addr_reg <= wcnt_reg;
        buf_wr_data_reg <= in_data;
      end
      if (close) begin
        wcnt_reg    <= '0;
        wr_bank_reg <= ~wr_bank_reg;
      end else if (accept) begin
        wcnt_reg <= wcnt_reg + ADDR_WIDTH'(1);
      end
      if (len_bad) err_len_reg <= 1'b1;

      if (start)                    timer_reg <= '0;
      else if (state_reg == C_RUN)  timer_reg <= timer_reg + TW'(1);
      if (enc_drop)                 err_timeout_reg <= 1'b1;
      if (enc_done || enc_drop)     enc_bank_reg <= ~enc_bank_reg;
      if (rd_ack)                   rd_bank_reg <= ~rd_bank_reg;
    end
  end

  assign buf_we      = buf_we_reg;
  assign buf_bank    = buf_bank_reg;
  assign buf_wr_addr = buf_wr_addr_reg;
  assign buf_wr_data = buf_wr_data_reg;
  assign core_en     = core_en_reg;
  assign core_clr    = core_clr_reg;
  assign core_bank   = core_bank_reg;
  assign err_len     = err_len_reg;
  assign err_timeout = err_timeout_reg;
  assign busy        = (bank_reg[0] != EMPTY) || (bank_reg[1] != EMPTY) || (state_reg != C_IDLE);

endmodule

// File: tb/tb_ldpc_frame_sched.sv
// Directed bench for ldpc_frame_sched: default instance plus a TIMEOUT=100 instance
// sharing the stream inputs; the second one's core never completes.
`define CHK(t, o, e) chk(t, 512'(o), 512'(e))

module tb_ldpc_frame_sched;
  localparam int DW = 360;
  localparam int AW = 7;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic in_last = 1'b0;
  logic frm_ack = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic auto_core = 1'b0;
  logic man_done = 1'b0;
  logic t_core_done = 1'b0;
  logic core_done;

  logic in_ready, buf_we, buf_bank, core_en, core_bank, core_clr;
  logic frm_valid, frm_bank, err_len, err_timeout, busy;
  logic [AW-1:0] buf_wr_addr;
  logic [DW-1:0] buf_wr_data;

  logic t_in_ready, t_buf_we, t_buf_bank, t_core_en, t_core_bank, t_core_clr;
  logic t_frm_valid, t_frm_bank, t_err_len, t_err_timeout, t_busy;
  logic [AW-1:0] t_buf_wr_addr;
  logic [DW-1:0] t_buf_wr_data;

  int n_checks = 0;
  int n_fail = 0;

  // Loopback core: finishes one cycle after it is enabled.
  assign core_done = auto_core ? core_en : man_done;

  always #5 clk = ~clk;

  ldpc_frame_sched dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .buf_we(buf_we), .buf_bank(buf_bank), .buf_wr_addr(buf_wr_addr),
    .buf_wr_data(buf_wr_data), .core_en(core_en), .core_bank(core_bank), .core_clr(core_clr),
    .core_done(core_done), .frm_valid(frm_valid), .frm_bank(frm_bank), .frm_ack(frm_ack),
    .err_len(err_len), .err_timeout(err_timeout), .busy(busy)
  );

  ldpc_frame_sched #(.TIMEOUT(100)) dut_to (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(t_in_ready), .in_data(in_data),
    .in_last(in_last), .buf_we(t_buf_we), .buf_bank(t_buf_bank), .buf_wr_addr(t_buf_wr_addr),
    .buf_wr_data(t_buf_wr_data), .core_en(t_core_en), .core_bank(t_core_bank),
    .core_clr(t_core_clr), .core_done(t_core_done), .frm_valid(t_frm_valid),
    .frm_bank(t_frm_bank), .frm_ack(frm_ack), .err_len(t_err_len),
    .err_timeout(t_err_timeout), .busy(t_busy)
  );

  always @(negedge clk) begin
    n_checks++;
    if ((core_clr && core_en) || (t_core_clr && t_core_en)) begin
      n_fail++;
      $error("FAIL mon_clr_en core_clr=%0b core_en=%0b t_core_clr=%0b t_core_en=%0b",
             core_clr, core_en, t_core_clr, t_core_en);
    end
    n_checks++;
    if (rst && (in_ready || frm_valid || t_in_ready || t_frm_valid)) begin
      n_fail++;
      $error("FAIL mon_rst in_ready=%0b frm_valid=%0b", in_ready, frm_valid);
    end
    n_checks++;
    if ((buf_we && (buf_wr_addr > AW'(71))) || (t_buf_we && (t_buf_wr_addr > AW'(71)))) begin
      n_fail++;
      $error("FAIL mon_addr buf_wr_addr=%0d t_buf_wr_addr=%0d", buf_wr_addr, t_buf_wr_addr);
    end
  end

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] dat(input int f, input int i);
    logic [DW-1:0] d;
    d = '0;
    d[15:0]       = 16'(f * 256 + i);
    d[180 +: 16]  = ~16'(i);
    d[DW-1 -: 32] = 32'(f * 32'h9E3779B1 + i);
    return d;
  endfunction

  task automatic send_word(input int f, input int i, input logic last, input logic eb);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = dat(f, i);
    in_last  = last;
    while (!in_ready && n < 1000) begin
      tick();
      n++;
    end
    `CHK("in_ready_wait", in_ready, 1'b1);
    tick();
    `CHK("buf_we", buf_we, 1'b1);
    `CHK("buf_bank", buf_bank, eb);
    `CHK("buf_wr_addr", buf_wr_addr, i[AW-1:0]);
    `CHK("buf_wr_data", buf_wr_data, dat(f, i));
  endtask

  task automatic send_frame(input int f, input int nw, input int last_at, input logic eb);
    for (int i = 0; i < nw; i++) send_word(f, i, (i == last_at), eb);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_frm(input logic eb);
    int n;
    n = 0;
    while (!frm_valid && n < 1000) begin
      tick();
      n++;
    end
    `CHK("frm_valid", frm_valid, 1'b1);
    `CHK("frm_bank", frm_bank, eb);
  endtask

  task automatic ack();
    frm_ack = 1'b1;
    tick();
    frm_ack = 1'b0;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    frm_ack  = 1'b0;
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    `CHK("rst_in_ready", in_ready, 1'b0);
    `CHK("rst_frm_valid", frm_valid, 1'b0);
    `CHK("rst_busy", busy, 1'b0);
    `CHK("rst_buf_we", buf_we, 1'b0);
    `CHK("rst_core_en", core_en, 1'b0);
    `CHK("rst_core_clr", core_clr, 1'b0);
    `CHK("rst_err_len", err_len, 1'b0);
    `CHK("rst_err_timeout", err_timeout, 1'b0);
    rst = 1'b0;
    tick();
    `CHK("idle_in_ready", in_ready, 1'b1);
    `CHK("idle_busy", busy, 1'b0);

    // Single frame, core returns done 300 cycles after enable
    send_frame(1, 72, 71, 1'b0);
    `CHK("f1_core_en_latency", core_en, 1'b0);
    `CHK("f1_busy", busy, 1'b1);
    `CHK("f1_err_len", err_len, 1'b0);
    tick();
    `CHK("f1_core_en", core_en, 1'b1);
    `CHK("f1_core_bank", core_bank, 1'b0);
    `CHK("f1_core_clr_idle", core_clr, 1'b0);
    repeat (299) tick();
    `CHK("f1_core_en_hold", core_en, 1'b1);
    man_done = 1'b1;
    tick();
    `CHK("f1_core_en_off", core_en, 1'b0);
    `CHK("f1_core_clr", core_clr, 1'b1);
    `CHK("f1_frm_valid", frm_valid, 1'b1);
    `CHK("f1_frm_bank", frm_bank, 1'b0);
    tick();
    `CHK("f1_core_clr_once", core_clr, 1'b0);
    `CHK("f1_core_en_clr", core_en, 1'b0);
    man_done = 1'b0;
    tick();
    `CHK("f1_busy_done", busy, 1'b1);
    ack();
    `CHK("f1_frm_valid_ack", frm_valid, 1'b0);
    `CHK("f1_busy_idle", busy, 1'b0);

    // Three back-to-back frames with frm_ack held low
    do_reset();
    auto_core = 1'b1;
    send_frame(11, 72, 71, 1'b0);
    send_frame(12, 72, 71, 1'b1);
    `CHK("b2b_stall_after_f2", in_ready, 1'b0);
    in_valid = 1'b1;
    in_data  = dat(13, 0);
    in_last  = 1'b0;
    repeat (4) tick();
    `CHK("b2b_stall_hold", in_ready, 1'b0);
    `CHK("b2b_no_write", buf_we, 1'b0);
    wait_frm(1'b0);
    frm_ack = 1'b1;
    `CHK("b2b_ack_same_cycle", in_ready, 1'b0);
    tick();
    frm_ack = 1'b0;
    `CHK("b2b_ack_next_cycle", in_ready, 1'b1);
    wait_frm(1'b1);
    send_frame(13, 72, 71, 1'b0);
    ack();
    wait_frm(1'b0);
    ack();
    `CHK("b2b_busy_idle", busy, 1'b0);

    // Early in_last on word 40
    do_reset();
    auto_core = 1'b0;
    man_done  = 1'b0;
    send_frame(4, 41, 40, 1'b0);
    `CHK("short_err_len", err_len, 1'b1);
    `CHK("short_in_ready", in_ready, 1'b1);
    `CHK("short_core_en_latency", core_en, 1'b0);
    tick();
    `CHK("short_full_core_en", core_en, 1'b1);
    `CHK("short_full_core_bank", core_bank, 1'b0);
    send_frame(5, 3, -1, 1'b1);
    `CHK("short_err_len_sticky", err_len, 1'b1);

    // Timeout on the TIMEOUT=100 instance
    do_reset();
    auto_core   = 1'b1;
    t_core_done = 1'b0;
    send_frame(6, 72, 71, 1'b0);
    send_frame(7, 72, 71, 1'b1);
    `CHK("to_buf_we", t_buf_we, 1'b1);
    `CHK("to_buf_bank", t_buf_bank, 1'b1);
    `CHK("to_buf_wr_addr", t_buf_wr_addr, 7'd71);
    `CHK("to_buf_wr_data", t_buf_wr_data, dat(7, 71));
    `CHK("to_in_ready_stall", t_in_ready, 1'b0);
    `CHK("to_err_len", t_err_len, 1'b0);
    `CHK("to_core_en_run", t_core_en, 1'b1);
    `CHK("to_core_bank_run", t_core_bank, 1'b0);
    `CHK("to_busy", t_busy, 1'b1);
    repeat (28) tick();
    `CHK("to_err_before", t_err_timeout, 1'b0);
    `CHK("to_core_en_before", t_core_en, 1'b1);
    tick();
    `CHK("to_err_timeout", t_err_timeout, 1'b1);
    `CHK("to_core_clr", t_core_clr, 1'b1);
    `CHK("to_core_en_off", t_core_en, 1'b0);
    `CHK("to_frm_valid", t_frm_valid, 1'b0);
    `CHK("to_in_ready_dropped", t_in_ready, 1'b1);
    tick();
    `CHK("to_core_clr_once", t_core_clr, 1'b0);
    `CHK("to_core_en_clr", t_core_en, 1'b0);
    tick();
    `CHK("to_next_core_en", t_core_en, 1'b1);
    `CHK("to_next_core_bank", t_core_bank, 1'b1);
    `CHK("to_frm_valid_after", t_frm_valid, 1'b0);
    `CHK("to_frm_bank", t_frm_bank, 1'b0);

    // Reset mid-frame while the previous frame is being encoded
    do_reset();
    auto_core = 1'b0;
    man_done  = 1'b0;
    send_frame(8, 72, 71, 1'b0);
    send_frame(9, 30, -1, 1'b1);
    `CHK("mr_core_en_enc", core_en, 1'b1);
    in_valid = 1'b1;
    in_data  = dat(9, 30);
    rst      = 1'b1;
    tick();
    `CHK("mr_in_ready", in_ready, 1'b0);
    `CHK("mr_frm_valid", frm_valid, 1'b0);
    `CHK("mr_busy", busy, 1'b0);
    `CHK("mr_buf_we", buf_we, 1'b0);
    `CHK("mr_core_en", core_en, 1'b0);
    `CHK("mr_core_clr", core_clr, 1'b0);
    `CHK("mr_err_len", err_len, 1'b0);
    `CHK("mr_err_timeout", err_timeout, 1'b0);
    `CHK("mr_t_err_timeout", t_err_timeout, 1'b0);
    rst      = 1'b0;
    in_valid = 1'b0;
    tick();
    `CHK("mr_enc_discarded", core_en, 1'b0);
    send_frame(10, 2, -1, 1'b0);
    `CHK("mr_no_restart", core_en, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
